sec_countdown_timer: RTL and testbench
======================================

Name: sec_countdown_timer

Overview:
- Consumes the 1 Hz square wave from the clock divider and turns it into an mm:ss countdown timer with start, pause and load control.
- Detects each rising edge of the 1 Hz wave in the system clock domain and decrements a BCD minutes:seconds count once per edge.
- Outputs feed the seven-segment display driver and the appliance control FSM, which uses the done/expired signals.

Parameters:
- RST_MIN, 8'h00, BCD minutes value loaded at reset.
- RST_SEC, 8'h30, BCD seconds value loaded at reset.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous reset, active-low.
- tick_in  in  1  1 Hz square wave from the divider, synchronous to clk. Each rising edge = one second.
- load  in  1  one-cycle pulse; loads load_min/load_sec.
- load_min  in  8  BCD minutes {tens, ones}, 00..99.
- load_sec  in  8  BCD seconds {tens, ones}, 00..59.
- start  in  1  one-cycle pulse; begins or resumes counting.
- pause  in  1  one-cycle pulse; freezes counting.
- min_out  out  8  current BCD minutes.
- sec_out  out  8  current BCD seconds.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the count reaches 00:00.
- expired  out  1  level; high in EXPIRED.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; min_out=RST_MIN, sec_out=RST_SEC.
  - reload register = {RST_MIN, RST_SEC}.
  - tick_d=0; running=0, done=0, expired=0.
  - Reset mid-count discards the count immediately.
- Tick detect:
  - tick_d is a register of tick_in; sec_tick = tick_in & ~tick_d.
  - The count updates on the clk edge following the cycle in which sec_tick=1, i.e. 1 cycle latency.
  - Only rising edges count, so a level held high counts once.
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- Control priority in a single cycle: load > pause > start > sec_tick.
- load, in any state:
  - min_out/sec_out and the reload register take the sanitised inputs; state goes to IDLE; expired clears.
  - Any tick in the same cycle is dropped.
  - Sanitise: any BCD digit >9 becomes 9; seconds tens >5 becomes 5.
- start:
  - IDLE with count != 00:00 -> RUN.
  - PAUSE -> RUN.
  - Ignored in IDLE at 00:00, in RUN and in EXPIRED.
  - A sec_tick in the same cycle is not applied.
- pause:
  - RUN -> PAUSE, and the count holds.
  - Ignored in all other states.
- Decrement in RUN on sec_tick:
  - If sec != 00: decrement seconds. Ones 0 -> 9 with tens-1; otherwise ones-1.
  - Else if min != 00: decrement minutes the same way and set sec = 59.
  - Never wraps below 00:00.
- Expiry:
  - The decrement that produces 00:00 also asserts done=1 for exactly that one cycle, and the state goes to EXPIRED.
  - EXPIRED holds 00:00 with expired=1, ignoring start, pause and tick, until load or reset.
- running = (state == RUN). done is 0 in every other cycle.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined: on expiry, done still pulses, but the count reloads from the reload register in that same update. The state stays RUN, EXPIRED is unreachable, and expired stays 0. A reload value of 00:00 is ignored for start, so no free-run at zero occurs.
- Undefined: expiry behaves as described under Behaviour.

Decomposition:
- Shared PARAMETER.v header holds:
  - state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_EXPIRED (2-bit);
  - BCD_NINE=4'd9, SEC_TENS_MAX=4'd5, BCD_ZERO8=8'h00.
- One combinational sub-module, mmss_bcd_decrement:
  - inputs min/sec BCD; outputs next min/sec and a zero flag;
  - holds all digit-borrow logic, keeping the top level to the FSM, edge detect and registers.

Test Plan:
- Reset with defaults -> min_out=00, sec_out=30, running=0, expired=0. Start, then 30 tick_in rising edges -> sec_out steps 29..00, done pulses 1 cycle on the 30th, expired=1.
- Load 01:00, start, 1 tick -> 00:59. Continue 59 ticks -> done, expired=1. Load 12:34 -> IDLE, expired=0, output 12:34.
- Load 00:05, start, 2 ticks, pause, 3 ticks -> holds 00:03. Start, 1 tick -> 00:02.
- Hold tick_in high for 10 cycles in RUN -> single decrement only. Start and tick rising together -> no decrement that cycle. Load and tick together -> loaded value exact.
- Load 8'hAF / 8'h7C -> sanitised to 99:59. Load 00:00, then start -> remains IDLE, running=0.
- With TIMER_AUTO_RELOAD_EN: load 00:02, start, 2 ticks -> done pulse, output 00:02, running=1, expired=0. Assert reset mid-count -> outputs return to RST values asynchronously.

Source files
------------

// File: rtl/sec_countdown_timer_pkg.sv
// Shared types, constants and BCD helpers for the mm:ss countdown timer.
package sec_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [7:0] BCD_ZERO8    = 8'h00;

    // Clamp a nibble to a legal decimal digit no larger than max_digit.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_digit);
        return (d > max_digit) ? max_digit : d;
    endfunction

    function automatic logic [7:0] sanitise_min(input logic [7:0] v);
        return {clamp_digit(v[7:4], BCD_NINE), clamp_digit(v[3:0], BCD_NINE)};
    endfunction

    function automatic logic [7:0] sanitise_sec(input logic [7:0] v);
        return {clamp_digit(v[7:4], SEC_TENS_MAX), clamp_digit(v[3:0], BCD_NINE)};
    endfunction

    // Two-digit BCD decrement; callers guarantee v != 00.
    function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, BCD_NINE};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/sec_countdown_timer_if.sv
// Control/status bundle between the countdown timer and its controller.
interface sec_countdown_timer_if;
    logic       tick_in;
    logic       load;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic       start;
    logic       pause;
    logic [7:0] min_out;
    logic [7:0] sec_out;
    logic       running;
    logic       done;
    logic       expired;

    modport master (
        output tick_in, load, load_min, load_sec, start, pause,
        input  min_out, sec_out, running, done, expired
    );

    modport slave (
        input  tick_in, load, load_min, load_sec, start, pause,
        output min_out, sec_out, running, done, expired
    );
endinterface

// File: rtl/sec_countdown_timer_bcd_decrement.sv
// Combinational one-second decrement of a BCD mm:ss value; never goes below 00:00.
module mmss_bcd_decrement
    import sec_countdown_timer_pkg::*;
(
    input  logic [7:0] min,
    input  logic [7:0] sec,
    output logic [7:0] next_min,
    output logic [7:0] next_sec,
    output logic       zero
);

    always_comb begin
        next_min = min;
        next_sec = sec;
        if (sec != BCD_ZERO8) begin
            next_sec = bcd_dec8(sec);
        end else if (min != BCD_ZERO8) begin
            next_min = bcd_dec8(min);
            next_sec = {SEC_TENS_MAX, BCD_NINE};
        end
    end

    // Flags only a real step that lands on 00:00, not a value already at zero.
    assign zero = (next_min == BCD_ZERO8) && (next_sec == BCD_ZERO8) &&
                  ((min != BCD_ZERO8) || (sec != BCD_ZERO8));

endmodule

// File: rtl/sec_countdown_timer.sv
// mm:ss countdown timer driven by rising edges of a 1 Hz wave.
// Optional TIMER_AUTO_RELOAD_EN: reload from the last loaded value on expiry instead of stopping.
module sec_countdown_timer
    import sec_countdown_timer_pkg::*;
#(
    parameter logic [7:0] RST_MIN = 8'h00,
    parameter logic [7:0] RST_SEC = 8'h30
) (
    input  logic                  clk,
    input  logic                  reset,
    sec_countdown_timer_if.slave  bus
);

    state_t     state_reg, state_next;
    logic [7:0] min_reg, min_next;
    logic [7:0] sec_reg, sec_next;
    logic       tick_d_reg;
    logic       done_reg, done_next;
    logic       running_reg, expired_reg;
`ifdef TIMER_AUTO_RELOAD_EN
    logic [15:0] reload_reg, reload_next;
`endif

    logic       sec_tick;
    logic       count_zero;
    logic [7:0] dec_min, dec_sec;
    logic       dec_zero;

    assign sec_tick   = bus.tick_in & ~tick_d_reg;
    assign count_zero = (min_reg == BCD_ZERO8) && (sec_reg == BCD_ZERO8);

    mmss_bcd_decrement u_dec (
        .min      (min_reg),
        .sec      (sec_reg),
        .next_min (dec_min),
        .next_sec (dec_sec),
        .zero     (dec_zero)
    );

    // Priority load > pause > start > tick: a higher control swallows any lower one that cycle.
    always_comb begin
        state_next  = state_reg;
        min_next    = min_reg;
        sec_next    = sec_reg;
        done_next   = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        reload_next = reload_reg;
`endif
        if (bus.load) begin
            min_next   = sanitise_min(bus.load_min);
            sec_next   = sanitise_sec(bus.load_sec);
            state_next = ST_IDLE;
`ifdef TIMER_AUTO_RELOAD_EN
            reload_next = {sanitise_min(bus.load_min), sanitise_sec(bus.load_sec)};
`endif
        end else if (bus.pause) begin
            if (state_reg == ST_RUN)
                state_next = ST_PAUSE;
        end else if (bus.start) begin
            if ((state_reg == ST_IDLE && !count_zero) || state_reg == ST_PAUSE)
                state_next = ST_RUN;
        end else if (sec_tick && state_reg == ST_RUN) begin
            min_next = dec_min;
            sec_next = dec_sec;
            if (dec_zero) begin
                done_next = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                min_next = reload_reg[15:8];
                sec_next = reload_reg[7:0];
`else
                state_next = ST_EXPIRED;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            min_reg     <= RST_MIN;
            sec_reg     <= RST_SEC;
            tick_d_reg  <= 1'b0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
            expired_reg <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            reload_reg  <= {RST_MIN, RST_SEC};
`endif
        end else begin
            state_reg   <= state_next;
            min_reg     <= min_next;
            sec_reg     <= sec_next;
            tick_d_reg  <= bus.tick_in;
            done_reg    <= done_next;
            running_reg <= (state_next == ST_RUN);
            expired_reg <= (state_next == ST_EXPIRED);
`ifdef TIMER_AUTO_RELOAD_EN
            reload_reg  <= reload_next;
`endif
        end
    end

    assign bus.min_out = min_reg;
    assign bus.sec_out = sec_reg;
    assign bus.running = running_reg;
    assign bus.done    = done_reg;
    assign bus.expired = expired_reg;

endmodule

// File: tb/tb_sec_countdown_timer.sv
// Directed bench for sec_countdown_timer; expected values are hand-computed BCD constants.
module tb_sec_countdown_timer;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    sec_countdown_timer_if bus ();

    sec_countdown_timer #(.RST_MIN(8'h00), .RST_SEC(8'h30)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        bus.load_min = m;
        bus.load_sec = s;
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_pause();
        bus.pause = 1'b1;
        cyc();
        bus.pause = 1'b0;
    endtask

    // Single rising edge on tick_in; d captures done in the update cycle, d2 one cycle later.
    task automatic do_tick(output logic d, output logic d2);
        bus.tick_in = 1'b1;
        cyc();
        d = bus.done;
        bus.tick_in = 1'b0;
        cyc();
        d2 = bus.done;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    initial begin
        logic d, d2;
        n_assert = 0;
        n_fail   = 0;
        bus.tick_in = 0; bus.load = 0; bus.start = 0; bus.pause = 0;
        bus.load_min = 8'h00; bus.load_sec = 8'h00;
        reset = 1'b0;
        repeat (3) cyc();
        chk("rst_mmss", {bus.min_out, bus.sec_out}, 16'h0030);
        chk("rst_flags", {13'd0, bus.running, bus.done, bus.expired}, 16'd0);
        reset = 1'b1;
        cyc();

        // Default 00:30 countdown
        do_start();
        chk("start_running", {15'd0, bus.running}, 16'd1);
        for (int i = 1; i <= 30; i++) begin
            do_tick(d, d2);
`ifdef TIMER_AUTO_RELOAD_EN
            chk($sformatf("cnt30_sec_%0d", i), {8'h00, bus.sec_out}, {8'h00, (i == 30) ? 8'h30 : to_bcd(30 - i)});
`else
            chk($sformatf("cnt30_sec_%0d", i), {8'h00, bus.sec_out}, {8'h00, to_bcd(30 - i)});
`endif
            chk($sformatf("cnt30_done_%0d", i), {15'd0, d}, {15'd0, (i == 30)});
        end
        chk("cnt30_done_off", {15'd0, d2}, 16'd0);
`ifdef TIMER_AUTO_RELOAD_EN
        chk("cnt30_flags", {14'd0, bus.running, bus.expired}, 16'b10);
`else
        chk("cnt30_flags", {14'd0, bus.running, bus.expired}, 16'b01);
        do_start();
        do_tick(d, d2);
        chk("exp_hold", {bus.min_out, bus.sec_out}, 16'h0000);
        chk("exp_flags", {14'd0, bus.running, bus.expired}, 16'b01);
`endif

        // 01:00 rolls through minutes
        do_load(8'h01, 8'h00);
        chk("ld0100", {bus.min_out, bus.sec_out}, 16'h0100);
        chk("ld0100_exp", {15'd0, bus.expired}, 16'd0);
        do_start();
        do_tick(d, d2);
        chk("m_borrow", {bus.min_out, bus.sec_out}, 16'h0059);
        for (int i = 58; i >= 0; i--) begin
            do_tick(d, d2);
            if (i == 0) chk("m_done", {15'd0, d}, 16'd1);
        end
`ifdef TIMER_AUTO_RELOAD_EN
        chk("m_end", {bus.min_out, bus.sec_out}, 16'h0100);
`else
        chk("m_end", {bus.min_out, bus.sec_out}, 16'h0000);
        chk("m_expired", {15'd0, bus.expired}, 16'd1);
`endif
        do_load(8'h12, 8'h34);
        chk("ld1234", {bus.min_out, bus.sec_out}, 16'h1234);
        chk("ld1234_flags", {14'd0, bus.running, bus.expired}, 16'd0);

        // Pause / resume
        do_load(8'h00, 8'h05);
        do_start();
        do_tick(d, d2);
        do_tick(d, d2);
        chk("pre_pause", {bus.min_out, bus.sec_out}, 16'h0003);
        do_pause();
        chk("pause_run", {15'd0, bus.running}, 16'd0);
        repeat (3) do_tick(d, d2);
        chk("pause_hold", {bus.min_out, bus.sec_out}, 16'h0003);
        do_start();
        do_tick(d, d2);
        chk("resume", {bus.min_out, bus.sec_out}, 16'h0002);

        // Level held high counts once
        bus.tick_in = 1'b1;
        repeat (10) cyc();
        bus.tick_in = 1'b0;
        cyc();
        chk("level_once", {bus.min_out, bus.sec_out}, 16'h0001);

        // Start and tick together from PAUSE: no decrement
        do_pause();
        bus.start = 1'b1;
        bus.tick_in = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.tick_in = 1'b0;
        cyc();
        chk("start_tick_cnt", {bus.min_out, bus.sec_out}, 16'h0001);
        chk("start_tick_run", {15'd0, bus.running}, 16'd1);

        // Load and tick together: exact loaded value
        bus.tick_in = 1'b1;
        do_load(8'h00, 8'h45);
        bus.tick_in = 1'b0;
        cyc();
        chk("load_tick", {bus.min_out, bus.sec_out}, 16'h0045);
        chk("load_tick_run", {15'd0, bus.running}, 16'd0);

        // Sanitising and start at 00:00
        do_load(8'hAF, 8'h7C);
        chk("sanitise", {bus.min_out, bus.sec_out}, 16'h9959);
        do_load(8'h00, 8'h00);
        do_start();
        chk("zero_start", {15'd0, bus.running}, 16'd0);
        chk("zero_cnt", {bus.min_out, bus.sec_out}, 16'h0000);

`ifdef TIMER_AUTO_RELOAD_EN
        do_load(8'h00, 8'h02);
        do_start();
        do_tick(d, d2);
        do_tick(d, d2);
        chk("ar_done", {15'd0, d}, 16'd1);
        chk("ar_cnt", {bus.min_out, bus.sec_out}, 16'h0002);
        chk("ar_flags", {14'd0, bus.running, bus.expired}, 16'b10);
`endif

        // Asynchronous reset mid-count
        do_load(8'h00, 8'h10);
        do_start();
        do_tick(d, d2);
        chk("pre_rst", {bus.min_out, bus.sec_out}, 16'h0009);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", {bus.min_out, bus.sec_out}, 16'h0030);
        chk("async_rst_run", {15'd0, bus.running}, 16'd0);
        cyc();
        reset = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
